// File: rtl/operand_seq_pkg.sv
// Shared phase encoding and phase-advance rule for the operand sequencer.
package operand_seq_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        RESULT  = 2'b10
    } phase_t;

    // The unused encoding 2'b11 falls back to ENTER_A.
    function automatic logic [PHASE_W-1:0] advance(input logic [PHASE_W-1:0] p);
        logic [PHASE_W-1:0] n;
        n = ENTER_A;
        case (p)
            ENTER_A: n = ENTER_B;
            ENTER_B: n = RESULT;
            RESULT:  n = ENTER_A;
            default: n = ENTER_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/operand_sequencer_btn_debounce.sv
// Button conditioner: 2-flop sync, stable-count debounce, rising-edge pulse.
// Pulse appears DEBOUNCE_CYCLES+2 cycles after a clean press edge; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // Only presses generate a pulse; releases just update the level.
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_pulse <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_pulse;

endmodule

// File: rtl/operand_sequencer.sv
// Operand-entry controller for the CLA adder: A entry, B entry, result hold.
// Acts on debounced button pulses; store_a is combinational from the pulse, result registered.
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sw,
    input  logic               cin_sw,
    input  logic               btn_next,
    input  logic               btn_clear,
    output logic [WIDTH-1:0]   in_bus,
    output logic               store_a,
    output logic               cin,
    input  logic [WIDTH-1:0]   sum,
    input  logic               cout,
    output logic [WIDTH:0]     result,
    output logic               result_valid,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [PHASE_W-1:0] S_ENTER_A = ENTER_A;
    localparam logic [PHASE_W-1:0] S_ENTER_B = ENTER_B;
    localparam logic [PHASE_W-1:0] S_RESULT  = RESULT;
    localparam logic [PHASE_W-1:0] S_ILLEGAL = 2'b11;

    logic w_next;
    logic w_clear;
    logic w_next_level_unused;
    logic w_clear_level_unused;

    logic [PHASE_W-1:0] r_state;
    logic [WIDTH-1:0]   r_b;
    logic               r_cin;
    logic [WIDTH:0]     r_result;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_next),
        .level      (w_next_level_unused),
        .rise_pulse (w_next)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_clear),
        .level      (w_clear_level_unused),
        .rise_pulse (w_clear)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_ENTER_A;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_result <= '0;
        end else if (w_clear) begin
            r_state  <= S_ENTER_A;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_result <= '0;
        end else begin
            // B, its carry and the adder output are captured together so result matches in_bus/cin later.
            if (w_next && r_state == S_ENTER_B) begin
                r_b      <= sw;
                r_cin    <= cin_sw;
                r_result <= {cout, sum};
            end
            if (w_next || r_state == S_ILLEGAL) begin
                r_state <= advance(r_state);
            end
        end
    end

    always_comb begin
        store_a = 1'b0;
        in_bus  = sw;
        cin     = 1'b0;
        if (w_clear) begin
            // Loading zero through store_a clears the adder's A register.
            store_a = 1'b1;
            in_bus  = '0;
        end else begin
            case (r_state)
                S_ENTER_A: store_a = w_next;
                S_ENTER_B: cin     = cin_sw;
                S_RESULT: begin
                    in_bus = r_b;
                    cin    = r_cin;
                end
                default: ;
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = (r_state == S_RESULT);
    assign phase        = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed scenarios plus random button traffic vs. a history-window model.
module tb_operand_sequencer;
    import operand_seq_pkg::*;

    localparam int W   = 8;
    localparam int DBC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw;
    logic         cin_sw;
    logic         btn_next;
    logic         btn_clear;
    logic [W-1:0] in_bus;
    logic         store_a;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic [W:0]   result;
    logic         result_valid;
    logic [1:0]   phase;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DBC)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .cin_sw       (cin_sw),
        .btn_next     (btn_next),
        .btn_clear    (btn_clear),
        .in_bus       (in_bus),
        .store_a      (store_a),
        .cin          (cin),
        .sum          (sum),
        .cout         (cout),
        .result       (result),
        .result_valid (result_valid),
        .phase        (phase)
    );

    // Adder stub: A register loaded by store_a, combinational sum.
    logic [W-1:0] adder_a;
    always @(posedge clk or posedge rst)
        if (rst) adder_a <= '0;
        else if (store_a) adder_a <= in_bus;
    assign {cout, sum} = {1'b0, adder_a} + {1'b0, in_bus} + {{W{1'b0}}, cin};

    // Reference model: a button press is accepted once the raw input, seen two edges late,
    // has disagreed with the accepted level for DBC+1 consecutive samples.
    bit         hist_n[$];
    bit         hist_c[$];
    bit         acc_n, acc_c, p_n, p_c;
    logic [1:0] m_state;
    logic [W-1:0] m_a, m_b;
    logic       m_cinr;
    logic [W:0] m_res;

    function automatic bit flips(input bit q[$], input bit acc);
        int L;
        L = q.size();
        if (L < DBC + 3) return 1'b0;
        for (int i = L - 3 - DBC; i <= L - 3; i++)
            if (q[i] == acc) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_n.delete(); hist_c.delete();
            acc_n = 0; acc_c = 0; p_n = 0; p_c = 0;
            m_state = 2'b00; m_a = '0; m_b = '0; m_cinr = 0; m_res = '0;
        end else begin
            if (p_c) begin
                m_state = 2'b00; m_b = '0; m_cinr = 0; m_res = '0; m_a = '0;
            end else begin
                case (m_state)
                    2'b00: if (p_n) begin m_a = sw; m_state = 2'b01; end
                    2'b01: if (p_n) begin
                        m_b = sw; m_cinr = cin_sw;
                        m_res = {1'b0, m_a} + {1'b0, sw} + {{W{1'b0}}, cin_sw};
                        m_state = 2'b10;
                    end
                    2'b10: if (p_n) m_state = 2'b00;
                    default: m_state = 2'b00;
                endcase
            end
            hist_n.push_back(btn_next);
            hist_c.push_back(btn_clear);
            if (hist_n.size() > 40) void'(hist_n.pop_front());
            if (hist_c.size() > 40) void'(hist_c.pop_front());
            p_n = 0;
            if (flips(hist_n, acc_n)) begin acc_n = ~acc_n; p_n = acc_n; end
            p_c = 0;
            if (flips(hist_c, acc_c)) begin acc_c = ~acc_c; p_c = acc_c; end
        end
    end

    logic         exp_store, exp_cin, exp_rv;
    logic [W-1:0] exp_bus;
    always @* begin
        exp_store = p_c | (m_state == 2'b00 && p_n);
        exp_bus   = p_c ? '0 : (m_state == 2'b10 ? m_b : sw);
        exp_cin   = p_c ? 1'b0 : (m_state == 2'b01 ? cin_sw : (m_state == 2'b10 ? m_cinr : 1'b0));
        exp_rv    = (m_state == 2'b10);
    end

    task automatic press(input bit which_clear);
        if (which_clear) btn_clear = 1'b1; else btn_next = 1'b1;
        repeat (DBC + 8) @(negedge clk);
        btn_next = 1'b0; btn_clear = 1'b0;
        repeat (DBC + 8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = 8'h5A; cin_sw = 1'b1; btn_next = 0; btn_clear = 0;
        repeat (3) @(negedge clk);
        total++; if (phase !== 2'b00) begin bad++; $display("FAIL reset_phase got=%b want=00", phase); end
        total++; if (store_a !== 1'b0) begin bad++; $display("FAIL reset_store_a got=%b want=0", store_a); end
        total++; if (cin !== 1'b0) begin bad++; $display("FAIL reset_cin got=%b want=0", cin); end
        total++; if (result !== 9'h000) begin bad++; $display("FAIL reset_result got=%h want=000", result); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", result_valid); end
        total++; if (in_bus !== 8'h5A) begin bad++; $display("FAIL reset_in_bus got=%h want=5a", in_bus); end
        rst = 1'b0; cin_sw = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_enter_a();
        int n; bit seen;
        sw = 8'h25; cin_sw = 1'b0;
        btn_next = 1'b1; n = 0; seen = 0;
        while (n < 30 && !seen) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (store_a === 1'b1) seen = 1;
        end
        total++; if (!seen || n != DBC + 3) begin bad++; $display("FAIL enter_a_latency seen=%0d edges=%0d want=%0d", seen, n, DBC + 3); end
        total++; if (in_bus !== 8'h25) begin bad++; $display("FAIL enter_a_bus got=%h want=25", in_bus); end
        @(negedge clk);
        total++; if (store_a !== 1'b0) begin bad++; $display("FAIL enter_a_strobe_width got=%b want=0", store_a); end
        total++; if (phase !== 2'b01) begin bad++; $display("FAIL enter_a_phase got=%b want=01", phase); end
        total++; if (in_bus !== 8'h25) begin bad++; $display("FAIL enter_a_bus_hold got=%h want=25", in_bus); end
        btn_next = 1'b0;
        repeat (DBC + 8) @(negedge clk);
    endtask

    task automatic test_enter_b();
        int n;
        sw = 8'hF0; cin_sw = 1'b1;
        @(negedge clk);
        total++; if (cin !== 1'b1 || in_bus !== 8'hF0) begin bad++; $display("FAIL enter_b_live cin=%b bus=%h want 1/f0", cin, in_bus); end
        btn_next = 1'b1; n = 0;
        while (n < 30 && phase !== 2'b10) begin @(negedge clk); n++; end
        total++; if (phase !== 2'b10) begin bad++; $display("FAIL enter_b_phase got=%b want=10", phase); end
        total++; if (result !== 9'h116) begin bad++; $display("FAIL enter_b_result got=%h want=116", result); end
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL enter_b_valid got=%b want=1", result_valid); end
        total++; if (in_bus !== 8'hF0) begin bad++; $display("FAIL enter_b_bus got=%h want=f0", in_bus); end
        sw = 8'h33; cin_sw = 1'b0;
        @(negedge clk);
        total++; if (in_bus !== 8'hF0 || cin !== 1'b1 || result !== 9'h116) begin
            bad++; $display("FAIL result_hold bus=%h cin=%b res=%h want f0/1/116", in_bus, cin, result);
        end
        btn_next = 1'b0;
        repeat (DBC + 8) @(negedge clk);
    endtask

    task automatic test_bounce();
        bit pat[$]; int changes; logic [1:0] prev;
        for (int b = 0; b < 3; b++) begin pat.push_back(1); pat.push_back(1); pat.push_back(0); pat.push_back(0); end
        for (int h = 0; h < 20; h++) pat.push_back(1);
        changes = 0; prev = phase;
        foreach (pat[i]) begin
            btn_next = pat[i];
            @(negedge clk);
            total++; if (phase !== m_state || store_a !== exp_store) begin
                bad++; $display("FAIL bounce_cycle i=%0d phase=%b/%b store_a=%b/%b", i, phase, m_state, store_a, exp_store);
            end
            if (phase !== prev) changes++;
            prev = phase;
        end
        total++; if (changes != 1 || phase !== 2'b00) begin bad++; $display("FAIL bounce_pulses changes=%0d phase=%b want 1/00", changes, phase); end
        btn_next = 1'b0;
        repeat (DBC + 8) @(negedge clk);
    endtask

    task automatic test_clear_next();
        int n; bit seen;
        sw = 8'h81; press(0);
        sw = 8'h7E; cin_sw = 1'b1; press(0);
        total++; if (phase !== 2'b10 || result !== 9'h100) begin bad++; $display("FAIL cn_setup phase=%b res=%h want 10/100", phase, result); end
        btn_next = 1'b1; btn_clear = 1'b1; n = 0; seen = 0;
        while (n < 30 && !seen) begin @(negedge clk); n++; if (store_a === 1'b1) seen = 1; end
        total++; if (!seen || in_bus !== 8'h00) begin bad++; $display("FAIL cn_strobe seen=%0d bus=%h want 1/00", seen, in_bus); end
        @(negedge clk);
        total++; if (phase !== 2'b00 || result !== 9'h000 || result_valid !== 1'b0 || store_a !== 1'b0) begin
            bad++; $display("FAIL cn_after phase=%b res=%h valid=%b store=%b want 00/000/0/0", phase, result, result_valid, store_a);
        end
        n = 0;
        repeat (10) begin @(negedge clk); if (phase !== 2'b00) n++; end
        total++; if (n != 0) begin bad++; $display("FAIL cn_next_discarded cycles_off=%0d want=0", n); end
        btn_next = 1'b0; btn_clear = 1'b0;
        repeat (DBC + 8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n; bit seen;
        sw = 8'h11; press(0);
        cin_sw = 1'b1; sw = 8'h3C;
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (phase !== 2'b00 || store_a !== 1'b0 || cin !== 1'b0 || result !== 9'h000 || result_valid !== 1'b0 || in_bus !== 8'h3C) begin
            bad++; $display("FAIL mid_reset phase=%b store=%b cin=%b res=%h valid=%b bus=%h", phase, store_a, cin, result, result_valid, in_bus);
        end
        @(negedge clk);
        rst = 1'b0; n = 0; seen = 0;
        while (n < 30 && !seen) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (store_a === 1'b1) seen = 1;
        end
        total++; if (!seen || n != DBC + 3 || phase !== 2'b00) begin
            bad++; $display("FAIL mid_reset_restart seen=%0d edges=%0d phase=%b want 1/%0d/00", seen, n, phase, DBC + 3);
        end
        @(negedge clk);
        total++; if (phase !== 2'b01) begin bad++; $display("FAIL mid_reset_advance got=%b want=01", phase); end
        btn_next = 1'b0; cin_sw = 1'b0;
        repeat (DBC + 8) @(negedge clk);
    endtask

    task automatic test_hold();
        int changes; logic [1:0] prev; int seg [4]; bit lvl;
        press(1);
        seg = '{100, 20, 20, 20};
        changes = 0; prev = phase; lvl = 1;
        foreach (seg[s]) begin
            btn_next = lvl;
            repeat (seg[s]) begin
                @(negedge clk);
                total++; if (phase !== m_state || store_a !== exp_store || in_bus !== exp_bus) begin
                    bad++; $display("FAIL hold_cycle phase=%b/%b store=%b/%b bus=%h/%h", phase, m_state, store_a, exp_store, in_bus, exp_bus);
                end
                if (phase !== prev) changes++;
                prev = phase;
            end
            lvl = ~lvl;
        end
        total++; if (changes != 2 || phase !== 2'b10) begin bad++; $display("FAIL hold_pulses changes=%0d phase=%b want 2/10", changes, phase); end
        btn_next = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(5) == 0) btn_next = ~btn_next;
            if ($urandom_range(19) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(49) == 0) begin sw = 8'($urandom); cin_sw = 1'($urandom); end
            @(negedge clk);
            total++;
            if (store_a !== exp_store || in_bus !== exp_bus || (!p_c && cin !== exp_cin) ||
                result !== m_res || result_valid !== exp_rv || phase !== m_state) begin
                bad++;
                $display("FAIL random c=%0d store=%b/%b bus=%h/%h cin=%b/%b res=%h/%h valid=%b/%b phase=%b/%b",
                         c, store_a, exp_store, in_bus, exp_bus, cin, exp_cin, result, m_res,
                         result_valid, exp_rv, phase, m_state);
            end
        end
        btn_next = 1'b0; btn_clear = 1'b0;
        repeat (DBC + 8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_enter_a();
        test_enter_b();
        test_bounce();
        test_clear_next();
        test_reset_mid();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Front-end controller for the 8-bit CLA adder stage. It turns raw board switches and two push-buttons into a clean operand-entry sequence: enter A, enter B, show the result. It debounces and edge-detects both buttons and drives the adder's operand bus, `store_a` strobe and carry-in. It also captures the adder's sum and carry-out into a stable result register for display logic downstream.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; must match the adder.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed to accept a button level change; minimum 1. Board builds override this to about 2^20.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sw`  in  WIDTH: raw operand switches; treated as quasi-static, not synchronized.
- `cin_sw`  in  1: carry-in switch.
- `btn_next`  in  1: raw, bouncy "advance" button; asynchronous.
- `btn_clear`  in  1: raw, bouncy "clear" button; asynchronous.
- `in_bus`  out  WIDTH: operand bus to the adder's `in`.
- `store_a`  out  1: one-cycle strobe that loads the adder's A register from `in_bus`.
- `cin`  out  1: carry-in to the adder.
- `sum`  in  WIDTH: adder sum (combinational from the adder).
- `cout`  in  1: adder carry-out.
- `result`  out  WIDTH+1: registered `{cout, sum}`.
- `result_valid`  out  1: high while in RESULT.
- `phase`  out  2: current state encoding.

## Operation
- States:
  - ENTER_A = 2'b00
  - ENTER_B = 2'b01
  - RESULT = 2'b10
  - 2'b11 is illegal and returns to ENTER_A on the next clock.
- ENTER_A:
  - `in_bus` = `sw`, `cin` = 0.
  - A `next` pulse asserts `store_a` for that cycle and moves to ENTER_B.
- ENTER_B:
  - `in_bus` = `sw` and `cin` = `cin_sw`, live, so the adder computes A + `sw` + `cin_sw`.
  - A `next` pulse does three things: `b_reg` <= `sw`, `cin_reg` <= `cin_sw`, `result` <= {`cout`, `sum`}, all sampled in that same cycle.
  - The state then moves to RESULT.
- RESULT:
  - `in_bus` = `b_reg`, `cin` = `cin_reg`, so the adder output stays consistent with `result`.
  - `result_valid` = 1.
  - A `next` pulse moves to ENTER_A; `result` holds its value, `result_valid` drops.
- Clear:
  - A `clear` pulse in any state forces ENTER_A, zeroes `b_reg`, `cin_reg` and `result`.
  - It also asserts `store_a` with `in_bus` = 0 for that cycle, which zeroes the adder's A register.
  - If `clear` and `next` pulse in the same cycle, clear wins and `next` is discarded.
- Debounce, per button:
  - Two-flop synchronizer feeds a counter.
  - The counter increments while the synchronized level differs from the accepted level, and resets to 0 when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the accepted level flips and the counter resets.
  - A rising edge of the accepted level gives a one-cycle pulse. Releases produce no pulse.
- Arithmetic: this block does no addition. `result` is exactly WIDTH+1 bits with `cout` as the MSB; no truncation.

## Timing
- Reset values: state ENTER_A, `store_a` 0, `cin` 0, `result` 0, `result_valid` 0, `b_reg` 0, `cin_reg` 0, accepted button levels 0, counters 0. `in_bus` = `sw`, since it is combinational in ENTER_A.
- Button latency: a press that stays clean from edge k gives a pulse in cycle k + 2 + `DEBOUNCE_CYCLES`. The state updates on the following edge.
- Glitch rejection: bounces shorter than `DEBOUNCE_CYCLES` cycles produce no pulse. A held button produces exactly one pulse.
- `store_a`: high for exactly one cycle. `in_bus` is stable in that cycle and in the next one.
- Reset mid-sequence returns immediately to reset values; any in-flight debounce count is lost.

## Structure
- Shared package `operand_seq_pkg` holds:
  - the state enum `phase_t` (ENTER_A, ENTER_B, RESULT);
  - the constant `PHASE_W` = 2.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `btn_raw`, `level`, `rise_pulse`) is instantiated twice, once per button.
- The FSM and the registers live in the top module.

## Test plan
- Reset, then `sw`=8'h25, clean `next` press → `store_a` pulses once, cycle 6 after press (DEBOUNCE_CYCLES=4), with `in_bus`=8'h25; `phase` goes to 01.
- In ENTER_B, `sw`=8'hF0, `cin_sw`=1, adder model returns `sum`=8'h16, `cout`=1 on `next` → `result`=9'h116, `phase`=10, `result_valid`=1, `in_bus` held at 8'hF0.
- Bouncy `next`: three 2-cycle pulses, then held high → exactly one pulse; none from the bounces.
- In RESULT, `next` and `clear` pulse in the same cycle → ENTER_A, `result`=0, `store_a` pulses with `in_bus`=0.
- `rst` asserted mid-debounce in ENTER_B → all outputs at reset values immediately; a later `next` press starts again from ENTER_A.
- Hold `next` for 100 cycles, release, press again → two pulses total; the sequence goes ENTER_A→ENTER_B→RESULT.
